control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/control_unit.sv | 111 +++++++++++
 tb/tb_control_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU select codes, control-unit state encoding
// and the per-opcode last-step lookup.
package cpu_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_IN   = 5'b10101;
   localparam logic [4:0] OP_OUT  = 5'b10110;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_NOP = 5'b00000;
   localparam logic [4:0] ALU_ADD = 5'b00011;

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_T7    = 4'd8,
      S_HALT  = 4'd9
   } state_t;

   // Final execute step of each instruction; never a fetch state, so a match
   // against the current state is only possible from T3 onward.
   function automatic state_t final_step(input logic [4:0] op);
      case (op)
         OP_LD, OP_ST:                                 final_step = S_T7;
         OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: final_step = S_T5;
         OP_BR:                                        final_step = S_T6;
         OP_JAL:                                       final_step = S_T4;
         default:                                      final_step = S_T3;
      endcase
   endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit: three-step fetch, opcode-driven execute steps,
// halt on the halt opcode or a stop request seen in an instruction's last step.
module control_unit
   import cpu_pkg::*;
(
   input  logic       clock,
   input  logic       clear,
   input  logic [4:0] ir_op,
   input  logic       con_ff,
   input  logic       stop,
   output logic       PCout,
   output logic       IncPC,
   output logic       ZLOout,
   output logic       ZLOin,
   output logic       Cout,
   output logic       MDRout,
   output logic       RAMenable,
   output logic       MARin,
   output logic       PCin,
   output logic       MDRin,
   output logic       IRin,
   output logic       Yin,
   output logic       Gra,
   output logic       Grb,
   output logic       Grc,
   output logic       Rin,
   output logic       Rout,
   output logic       BAout,
   output logic       read,
   output logic       write,
   output logic       conin,
   output logic       R15in,
   output logic       OutPortenable,
   output logic       PortInout,
   output logic [4:0] aluControl,
   output logic       run
);

   state_t state_q, state_d;
   logic   last_step;

   always_ff @(posedge clock) begin
      if (clear) state_q <= S_RESET;
      else       state_q <= state_d;
   end

   assign last_step = (state_q == final_step(ir_op));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_HALT:  state_d = S_HALT;
         S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (last_step) state_d = ((ir_op == OP_HALT) || stop) ? S_HALT : S_T0;
            else           state_d = state_t'(state_q + 4'd1);
         end
         default: state_d = S_RESET;
      endcase
   end

   always_comb begin
      {PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin,
       PCin, MDRin, IRin, Yin, Gra, Grb, Grc, Rin,
       Rout, BAout, read, write, conin, R15in, OutPortenable, PortInout} = '0;
      aluControl = ALU_NOP;
      run        = (state_q inside {[S_T0:S_T7]});
      case (state_q)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
         S_T1: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: case (ir_op)
            OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            OP_BR:  begin Gra = 1'b1; Rout = 1'b1; conin = 1'b1; end
            OP_JR:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_JAL: begin R15in = 1'b1; PCout = 1'b1; end
            OP_IN:  begin PortInout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPortenable = 1'b1; end
            OP_NOP, OP_HALT: ;
            default: ;
         endcase
         S_T4: case (ir_op)
            OP_LD, OP_LDI, OP_ST, OP_ADDI: begin Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD; end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = ir_op; end
            OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
            OP_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
         endcase
         S_T5: case (ir_op)
            OP_LD, OP_ST: begin ZLOout = 1'b1; MARin = 1'b1; end
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_BR:  begin Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD; end
            default: ;
         endcase
         S_T6: case (ir_op)
            OP_LD: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
            OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            OP_BR: begin ZLOout = 1'b1; PCin = con_ff; end
            default: ;
         endcase
         S_T7: case (ir_op)
            OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_ST: begin write = 1'b1; RAMenable = 1'b1; end
            default: ;
         endcase
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a step-table model checked every cycle plus
// hand-computed spot checks on the key instruction sequences.
module tb_control_unit;

   logic       clock = 1'b0;
   logic       clear, con_ff, stop;
   logic [4:0] ir_op;
   logic PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin, PCin, MDRin,
         IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, read, write, conin, R15in,
         OutPortenable, PortInout, run;
   logic [4:0]  aluControl;
   logic [23:0] strobes;

   control_unit dut (
      .clock(clock), .clear(clear), .ir_op(ir_op), .con_ff(con_ff), .stop(stop),
      .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .ZLOin(ZLOin), .Cout(Cout),
      .MDRout(MDRout), .RAMenable(RAMenable), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .read(read), .write(write), .conin(conin), .R15in(R15in),
      .OutPortenable(OutPortenable), .PortInout(PortInout),
      .aluControl(aluControl), .run(run)
   );

   always #5 clock = ~clock;

   assign strobes = {PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable, MARin,
                     PCin, MDRin, IRin, Yin, Gra, Grb, Grc, Rin,
                     Rout, BAout, read, write, conin, R15in, OutPortenable, PortInout};

   localparam logic [23:0] M_PCOUT  = 24'h800000, M_INCPC  = 24'h400000, M_ZLOOUT = 24'h200000,
                           M_ZLOIN  = 24'h100000, M_COUT   = 24'h080000, M_MDROUT = 24'h040000,
                           M_RAMEN  = 24'h020000, M_MARIN  = 24'h010000, M_PCIN   = 24'h008000,
                           M_MDRIN  = 24'h004000, M_IRIN   = 24'h002000, M_YIN    = 24'h001000,
                           M_GRA    = 24'h000800, M_GRB    = 24'h000400, M_GRC    = 24'h000200,
                           M_RIN    = 24'h000100, M_ROUT   = 24'h000080, M_BAOUT  = 24'h000040,
                           M_READ   = 24'h000020, M_WRITE  = 24'h000010, M_CONIN  = 24'h000008,
                           M_R15IN  = 24'h000004, M_OUTP   = 24'h000002, M_PORTIN = 24'h000001;
   localparam logic [23:0] FETCH0 = M_PCOUT | M_MARIN | M_INCPC;
   localparam logic [23:0] FETCH1 = M_READ | M_RAMEN | M_MDRIN;
   localparam logic [23:0] FETCH2 = M_MDROUT | M_IRIN;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: instruction length in cycles, and the strobe table for step k.
   function automatic int instr_len(input logic [4:0] op);
      case (op)
         5'b00000, 5'b00010: return 8;
         5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100: return 6;
         5'b10010: return 7;
         5'b10100: return 5;
         default:  return 4;
      endcase
   endfunction

   function automatic logic [28:0] exp_word(input logic [4:0] op, input int k, input logic c);
      logic [23:0] s;
      logic [4:0]  a;
      s = '0;
      a = '0;
      if (k == 0)      s = FETCH0;
      else if (k == 1) s = FETCH1;
      else if (k == 2) s = FETCH2;
      else case (op)
         5'b00000, 5'b00001, 5'b00010:
            case (k)
               3: s = M_GRB | M_BAOUT | M_YIN;
               4: begin s = M_COUT | M_ZLOIN; a = 5'b00011; end
               5: s = (op == 5'b00001) ? (M_ZLOOUT | M_GRA | M_RIN) : (M_ZLOOUT | M_MARIN);
               6: s = (op == 5'b00000) ? (M_READ | M_RAMEN | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
               7: s = (op == 5'b00000) ? (M_MDROUT | M_GRA | M_RIN) : (M_WRITE | M_RAMEN);
               default: ;
            endcase
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100:
            case (k)
               3: s = M_GRB | M_ROUT | M_YIN;
               4: begin
                  if (op == 5'b01100) begin s = M_COUT | M_ZLOIN; a = 5'b00011; end
                  else begin s = M_GRC | M_ROUT | M_ZLOIN; a = op; end
               end
               5: s = M_ZLOOUT | M_GRA | M_RIN;
               default: ;
            endcase
         5'b10010:
            case (k)
               3: s = M_GRA | M_ROUT | M_CONIN;
               4: s = M_PCOUT | M_YIN;
               5: begin s = M_COUT | M_ZLOIN; a = 5'b00011; end
               6: s = c ? (M_ZLOOUT | M_PCIN) : M_ZLOOUT;
               default: ;
            endcase
         5'b10011: if (k == 3) s = M_GRA | M_ROUT | M_PCIN;
         5'b10100: begin
            if (k == 3) s = M_R15IN | M_PCOUT;
            if (k == 4) s = M_GRA | M_ROUT | M_PCIN;
         end
         5'b10101: if (k == 3) s = M_PORTIN | M_GRA | M_RIN;
         5'b10110: if (k == 3) s = M_GRA | M_ROUT | M_OUTP;
         default: ;
      endcase
      return {a, s};
   endfunction

   localparam int MD_UNK = 0, MD_RESET = 1, MD_RUN = 2, MD_HALT = 3;
   int m_mode = MD_UNK;
   int m_k    = 0;

   always @(posedge clock) begin
      if (clear) m_mode <= MD_RESET;
      else if (m_mode == MD_RESET) begin
         m_mode <= MD_RUN;
         m_k    <= 0;
      end else if (m_mode == MD_RUN) begin
         if (m_k == instr_len(ir_op) - 1) begin
            if (ir_op == 5'b11011 || stop) m_mode <= MD_HALT;
            else m_k <= 0;
         end else m_k <= m_k + 1;
      end
   end

   logic [28:0] exp_w;
   always @(negedge clock) begin
      if (m_mode != MD_UNK) begin
         exp_w = (m_mode == MD_RUN) ? exp_word(ir_op, m_k, con_ff) : 29'd0;
         chk("cycle_strobes", 32'(strobes), 32'(exp_w[23:0]));
         chk("cycle_alu", 32'(aluControl), 32'(exp_w[28:24]));
         chk("cycle_run", 32'(run), 32'(m_mode == MD_RUN));
      end
   end

   int write_seen = 0;
   always @(negedge clock) if (write === 1'b1) write_seen = write_seen + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [4:0] loop_ops [11] = '{5'b00001, 5'b00011, 5'b00101, 5'b00110, 5'b01100,
                                 5'b10011, 5'b10101, 5'b10110, 5'b11010, 5'b11111, 5'b00010};
   int         loop_len [11] = '{6, 6, 6, 6, 6, 4, 4, 4, 4, 4, 8};

   initial begin
      clear = 1'b1; ir_op = 5'b0; con_ff = 1'b0; stop = 1'b0;
      tick(); tick();
      chk("reset_strobes", 32'(strobes), 32'd0);
      chk("reset_alu", 32'(aluControl), 32'd0);
      chk("reset_run", 32'(run), 32'd0);

      // jal: 5 cycles, T0 again on cycle 6
      clear = 1'b0; ir_op = 5'b10100;
      tick(); chk("jal_T0", 32'(strobes), 32'(FETCH0)); chk("jal_T0_run", 32'(run), 32'd1);
      tick(); chk("jal_T1", 32'(strobes), 32'(FETCH1));
      tick(); chk("jal_T2", 32'(strobes), 32'(FETCH2));
      tick(); chk("jal_T3", 32'(strobes), 32'(M_R15IN | M_PCOUT));
      tick(); chk("jal_T4", 32'(strobes), 32'(M_GRA | M_ROUT | M_PCIN));
      tick(); chk("jal_next_T0", 32'(strobes), 32'(FETCH0));

      // ld
      ir_op = 5'b00000;
      repeat (3) tick(); chk("ld_T3_alu", 32'(aluControl), 32'd0);
      tick(); chk("ld_T4_alu", 32'(aluControl), 32'h03);
      tick(); chk("ld_T5_alu", 32'(aluControl), 32'd0);
      tick(); chk("ld_T6", 32'(strobes), 32'(M_READ | M_RAMEN | M_MDRIN));
      tick(); chk("ld_T7", 32'(strobes), 32'(M_MDROUT | M_GRA | M_RIN));
      tick(); chk("ld_next_T0", 32'(strobes), 32'(FETCH0));

      // br, not taken then taken
      ir_op = 5'b10010; con_ff = 1'b0;
      repeat (6) tick(); chk("br0_T6", 32'(strobes), 32'(M_ZLOOUT));
      tick(); chk("br0_next_T0", 32'(strobes), 32'(FETCH0));
      con_ff = 1'b1;
      repeat (6) tick(); chk("br1_T6", 32'(strobes), 32'(M_ZLOOUT | M_PCIN));
      tick(); chk("br1_next_T0", 32'(strobes), 32'(FETCH0));

      // sub with an early stop that must be ignored, then a stop in the last step
      ir_op = 5'b00100; con_ff = 1'b0;
      tick(); stop = 1'b1;
      tick(); chk("sub_T2_run", 32'(run), 32'd1); chk("sub_T2", 32'(strobes), 32'(FETCH2));
      stop = 1'b0;
      tick(); chk("sub_T3", 32'(strobes), 32'(M_GRB | M_ROUT | M_YIN));
      tick(); chk("sub_T4_alu", 32'(aluControl), 32'h04);
      stop = 1'b1;
      tick(); chk("sub_T5_run", 32'(run), 32'd1);
      tick(); chk("sub_halt_run", 32'(run), 32'd0); chk("sub_halt_strobes", 32'(strobes), 32'd0);
      stop = 1'b0; clear = 1'b1;
      tick(); chk("sub_clear_run", 32'(run), 32'd0);
      clear = 1'b0;
      tick(); chk("sub_restart_T0", 32'(strobes), 32'(FETCH0));

      // remaining opcodes run end to end under the per-cycle model
      for (int i = 0; i < 11; i++) begin
         ir_op = loop_ops[i];
         repeat (loop_len[i]) tick();
         chk($sformatf("op_%b_next_T0", loop_ops[i]), 32'(strobes), 32'(FETCH0));
      end

      // st aborted by clear in T5
      ir_op = 5'b00010; write_seen = 0;
      repeat (5) tick(); chk("st_T5", 32'(strobes), 32'(M_ZLOOUT | M_MARIN));
      clear = 1'b1;
      tick(); chk("st_clear_strobes", 32'(strobes), 32'd0); chk("st_clear_run", 32'(run), 32'd0);
      clear = 1'b0;
      tick(); chk("st_clear_T0", 32'(strobes), 32'(FETCH0));
      chk("st_write_seen", 32'(write_seen), 32'd0);

      // halt opcode
      ir_op = 5'b11011;
      repeat (3) tick(); chk("halt_T3", 32'(strobes), 32'd0); chk("halt_T3_run", 32'(run), 32'd1);
      tick(); chk("halt_enter_run", 32'(run), 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick(); chk("halt_hold_run", 32'(run), 32'd0);
      end
      clear = 1'b1;
      tick(); chk("halt_clear_run", 32'(run), 32'd0);
      clear = 1'b0;
      tick(); chk("halt_restart_T0", 32'(strobes), 32'(FETCH0)); chk("halt_restart_run", 32'(run), 32'd1);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
